// File: rtl/hit_event_fifo.sv
// rtl/hit_event_fifo.sv - snapshots the sprite hit vector on busy fall, scans it, queues hit indices
// Optional HIT_FRAME_TAG_EN: tags each queued index with a 4-bit frame counter.
module hit_event_fifo #(
    parameter int SPRITE_NUM = 64,
    parameter int IDX_W      = $clog2(SPRITE_NUM),
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  hitCheckBusy,
    input  logic [SPRITE_NUM-1:0] allSpriteHit,
    input  logic                  irqEn,
    input  logic                  popReq,
    input  logic                  clrFlags,
    output logic [IDX_W-1:0]      hitIndex,
    output logic                  fifoEmpty,
    output logic [CNT_W-1:0]      fifoCount,
    output logic                  scanBusy,
    output logic                  scanDone,
    output logic                  overflow,
    output logic                  frameDropped,
`ifdef HIT_FRAME_TAG_EN
    output logic [3:0]            hitFrameTag,
`endif
    output logic                  hitIrq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef HIT_FRAME_TAG_EN
    localparam int ENTRY_W = IDX_W + 4;
`else
    localparam int ENTRY_W = IDX_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_NUM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                state_q, state_d;
    logic                  busy_dly_q, busy_dly_d;
    logic [SPRITE_NUM-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_dropped_q, frame_dropped_d;
    logic                  irq_q, irq_d;
    logic                  scan_busy_q, scan_busy_d;
    logic                  scan_done_q, scan_done_d;
    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    wdata;
    logic [ENTRY_W-1:0]    head;
    logic                  complete;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  drop_set;
`ifdef HIT_FRAME_TAG_EN
    logic [3:0]            tag_q, tag_d;
`endif

    always_comb begin
        busy_dly_d      = hitCheckBusy;
        complete        = busy_dly_q & ~hitCheckBusy;
        state_d         = state_q;
        snap_d          = snap_q;
        scan_idx_d      = scan_idx_q;
        push_req        = 1'b0;
        drop_set        = 1'b0;
`ifdef HIT_FRAME_TAG_EN
        tag_d           = tag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (complete) begin
                    snap_d     = allSpriteHit;
                    scan_idx_d = '0;
                    state_d    = S_SCAN;
`ifdef HIT_FRAME_TAG_EN
                    tag_d      = tag_q + 4'd1;
`endif
                end
            end
            default: begin
                push_req = snap_q[scan_idx_q];
                drop_set = complete;
                if (scan_idx_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    scan_idx_d = '0;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        pop     = popReq & ~empty_q;
        push_ok = push_req & ((count_q != FULL_CNT) | pop);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == '0);
        irq_d   = irqEn & ~empty_d;

        overflow_d      = (overflow_q & ~clrFlags) | (push_req & ~push_ok);
        frame_dropped_d = (frame_dropped_q & ~clrFlags) | drop_set;

        scan_busy_d = (state_d == S_SCAN);
        scan_done_d = (state_d == S_SCAN) && (scan_idx_d == LAST_IDX);

`ifdef HIT_FRAME_TAG_EN
        wdata = {tag_q, scan_idx_q};
`else
        wdata = scan_idx_q;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= S_IDLE;
            busy_dly_q      <= 1'b0;
            snap_q          <= '0;
            scan_idx_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            empty_q         <= 1'b1;
            overflow_q      <= 1'b0;
            frame_dropped_q <= 1'b0;
            irq_q           <= 1'b0;
            scan_busy_q     <= 1'b0;
            scan_done_q     <= 1'b0;
`ifdef HIT_FRAME_TAG_EN
            tag_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            busy_dly_q      <= busy_dly_d;
            snap_q          <= snap_d;
            scan_idx_q      <= scan_idx_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            empty_q         <= empty_d;
            overflow_q      <= overflow_d;
            frame_dropped_q <= frame_dropped_d;
            irq_q           <= irq_d;
            scan_busy_q     <= scan_busy_d;
            scan_done_q     <= scan_done_d;
`ifdef HIT_FRAME_TAG_EN
            tag_q           <= tag_d;
`endif
        end
    end

    // Entry storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign hitIndex     = empty_q ? '0 : head[IDX_W-1:0];
    assign fifoEmpty    = empty_q;
    assign fifoCount    = count_q;
    assign scanBusy     = scan_busy_q;
    assign scanDone     = scan_done_q;
    assign overflow     = overflow_q;
    assign frameDropped = frame_dropped_q;
    assign hitIrq       = irq_q;
`ifdef HIT_FRAME_TAG_EN
    assign hitFrameTag  = empty_q ? 4'd0 : head[IDX_W+:4];
`endif

endmodule

// File: tb/tb_hit_event_fifo.sv
// tb/tb_hit_event_fifo.sv - scoreboard bench for hit_event_fifo (optionally with HIT_FRAME_TAG_EN)
module tb_hit_event_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hitCheckBusy;
    logic [63:0] allSpriteHit;
    logic        irqEn;
    logic        popReq;
    logic        clrFlags;
    logic [5:0]  hitIndex;
    logic        fifoEmpty;
    logic [4:0]  fifoCount;
    logic        scanBusy;
    logic        scanDone;
    logic        overflow;
    logic        frameDropped;
    logic        hitIrq;
`ifdef HIT_FRAME_TAG_EN
    logic [3:0]  hitFrameTag;
`endif

    int checks = 0;
    int errors = 0;
    int sb_idx [$];
    int sb_tag [$];

    hit_event_fifo dut (
        .clk          (clk),
        .rstn         (rstn),
        .hitCheckBusy (hitCheckBusy),
        .allSpriteHit (allSpriteHit),
        .irqEn        (irqEn),
        .popReq       (popReq),
        .clrFlags     (clrFlags),
        .hitIndex     (hitIndex),
        .fifoEmpty    (fifoEmpty),
        .fifoCount    (fifoCount),
        .scanBusy     (scanBusy),
        .scanDone     (scanDone),
        .overflow     (overflow),
        .frameDropped (frameDropped),
`ifdef HIT_FRAME_TAG_EN
        .hitFrameTag  (hitFrameTag),
`endif
        .hitIrq       (hitIrq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic fire(input logic [63:0] vec);
        allSpriteHit = vec;
        hitCheckBusy = 1'b1;
        step();
        hitCheckBusy = 1'b0;
        step();
    endtask

    task automatic wait_scan();
        int n = 0;
        while (scanBusy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (scanBusy) begin
            errors++;
            $display("FAIL scan_timeout: scanBusy=%0d after %0d cycles, required 0", scanBusy, n);
        end
    endtask

    task automatic pop_check(input string name, input bit chk_tag);
        int exp_i;
        int exp_t;
        int guard = 0;
        while (sb_idx.size() != 0 && guard < 40) begin
            exp_i = sb_idx.pop_front();
            exp_t = sb_tag.pop_front();
            checks++;
            if (fifoEmpty !== 1'b0 || hitIndex !== 6'(exp_i)) begin
                errors++;
                $display("FAIL %s_pop: hitIndex=%0d empty=%0d, required %0d", name, hitIndex, fifoEmpty, exp_i);
            end
`ifdef HIT_FRAME_TAG_EN
            if (chk_tag) begin
                checks++;
                if (hitFrameTag !== 4'(exp_t)) begin
                    errors++;
                    $display("FAIL %s_tag: hitFrameTag=%0d, required %0d", name, hitFrameTag, exp_t);
                end
            end
`endif
            popReq = 1'b1;
            step();
            popReq = 1'b0;
            guard++;
        end
        checks++;
        if (fifoEmpty !== 1'b1 || fifoCount !== 5'd0) begin
            errors++;
            $display("FAIL %s_drained: empty=%0d count=%0d, required 1/0", name, fifoEmpty, fifoCount);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (hitIndex !== 6'd0 || fifoEmpty !== 1'b1 || fifoCount !== 5'd0 || scanBusy !== 1'b0 ||
            scanDone !== 1'b0 || overflow !== 1'b0 || frameDropped !== 1'b0 || hitIrq !== 1'b0) begin
            errors++;
            $display("FAIL %s: idx=%0d empty=%0d cnt=%0d busy=%0d done=%0d ovf=%0d drop=%0d irq=%0d, required 0/1/0/0/0/0/0/0",
                     name, hitIndex, fifoEmpty, fifoCount, scanBusy, scanDone, overflow, frameDropped, hitIrq);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_values");
        fire((64'd1 << 3) | (64'd1 << 40));
        for (int i = 0; i < 20; i++) step();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_scan");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 70; i++) step();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_single_frame();
        logic [63:0] vec;
        int n = 0;
        int done = 0;
        int exp_cnt;
        vec = (64'd1 << 5) | (64'd1 << 17) | (64'd1 << 63);
        irqEn = 1'b1;
        sb_idx = '{5, 17, 63};
        sb_tag = '{1, 1, 1};
        fire(vec);
        while (scanBusy && n < 200) begin
            exp_cnt = 0;
            for (int b = 0; b < n; b++) exp_cnt += int'(vec[b]);
            checks++;
            if (fifoCount !== 5'(exp_cnt) || hitIrq !== (exp_cnt != 0)) begin
                errors++;
                $display("FAIL single_scan_cycle%0d: count=%0d irq=%0d, required %0d/%0d",
                         n, fifoCount, hitIrq, exp_cnt, exp_cnt != 0);
            end
            if (scanDone) begin
                done++;
                checks++;
                if (n != 63) begin
                    errors++;
                    $display("FAIL single_done_cycle: scanDone at cycle %0d, required 63", n);
                end
            end
            step();
            n++;
        end
        checks++;
        if (n != 64 || done != 1) begin
            errors++;
            $display("FAIL single_scan_len: busy=%0d done=%0d, required 64/1", n, done);
        end
        checks++;
        if (fifoCount !== 5'd3 || hitIrq !== 1'b1) begin
            errors++;
            $display("FAIL single_after_scan: count=%0d irq=%0d, required 3/1", fifoCount, hitIrq);
        end
        pop_check("single", 1'b0);
        checks++;
        if (hitIrq !== 1'b0) begin
            errors++;
            $display("FAIL single_irq_drop: hitIrq=%0d, required 0", hitIrq);
        end
    endtask

    task automatic test_overflow();
        irqEn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb_idx.push_back(i);
            sb_tag.push_back(0);
        end
        fire({64{1'b1}});
        wait_scan();
        checks++;
        if (fifoCount !== 5'd16 || overflow !== 1'b1 || hitIrq !== 1'b0) begin
            errors++;
            $display("FAIL overflow_state: count=%0d ovf=%0d irq=%0d, required 16/1/0", fifoCount, overflow, hitIrq);
        end
        pop_check("overflow", 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: overflow=%0d, required 1", overflow);
        end
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: overflow=%0d, required 0", overflow);
        end
    endtask

    task automatic test_concurrent_pop();
        int seen = 0;
        int guard = 0;
        int exp_i;
        for (int i = 0; i < 64; i++) sb_idx.push_back(i);
        popReq = 1'b1;
        fire({64{1'b1}});
        while (sb_idx.size() != 0 && guard < 300) begin
            if (!fifoEmpty) begin
                exp_i = sb_idx.pop_front();
                seen++;
                checks++;
                if (hitIndex !== 6'(exp_i)) begin
                    errors++;
                    $display("FAIL concurrent_order: hitIndex=%0d, required %0d", hitIndex, exp_i);
                end
            end
            step();
            guard++;
        end
        popReq = 1'b0;
        sb_idx.delete();
        checks++;
        if (seen != 64 || overflow !== 1'b0 || fifoEmpty !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_summary: seen=%0d ovf=%0d empty=%0d, required 64/0/1", seen, overflow, fifoEmpty);
        end
    endtask

    task automatic test_frame_collision();
        do_reset();
        sb_idx = '{1, 2, 50};
        sb_tag = '{1, 1, 1};
        fire((64'd1 << 1) | (64'd1 << 2) | (64'd1 << 50));
        for (int i = 0; i < 10; i++) step();
        hitCheckBusy = 1'b1;
        step();
        allSpriteHit = 64'd1 << 7;
        hitCheckBusy = 1'b0;
        step();
        wait_scan();
        checks++;
        if (frameDropped !== 1'b1 || fifoCount !== 5'd3) begin
            errors++;
            $display("FAIL collision_state: drop=%0d count=%0d, required 1/3", frameDropped, fifoCount);
        end
        pop_check("collision", 1'b1);
        sb_idx = '{9};
        sb_tag = '{2};
        fire(64'd1 << 9);
        wait_scan();
        pop_check("next_frame", 1'b1);
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        checks++;
        if (frameDropped !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear: frameDropped=%0d, required 0", frameDropped);
        end
    endtask

    task automatic test_empty_pop();
        int n = 0;
        int done = 0;
        int bad = 0;
        irqEn = 1'b1;
        fire(64'd0);
        while (scanBusy && n < 200) begin
            if (scanDone) done++;
            if (!fifoEmpty || hitIrq) bad++;
            step();
            n++;
        end
        checks++;
        if (n != 64 || done != 1 || bad != 0) begin
            errors++;
            $display("FAIL zero_vector: busy=%0d done=%0d nonempty_cycles=%0d, required 64/1/0", n, done, bad);
        end
        popReq = 1'b1;
        step();
        popReq = 1'b0;
        step();
        checks++;
        if (fifoCount !== 5'd0 || fifoEmpty !== 1'b1 || hitIndex !== 6'd0 || hitIrq !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop: count=%0d empty=%0d idx=%0d irq=%0d, required 0/1/0/0",
                     fifoCount, fifoEmpty, hitIndex, hitIrq);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        hitCheckBusy = 1'b0;
        allSpriteHit = '0;
        irqEn        = 1'b0;
        popReq       = 1'b0;
        clrFlags     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_overflow();
        test_concurrent_pop();
        test_frame_collision();
        test_empty_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_event_fifo.md
Name: hit_event_fifo

Overview:
- Downstream consumer of the sprite collision checker's per-frame 64-bit hit vector.
- Detects completion of each hit check (falling edge of the checker busy flag) and snapshots the vector.
- Serially scans the snapshot and pushes the index of every hit sprite into a small FIFO.
- The CPU-side game logic pops the FIFO to apply explosions and score; an interrupt line is raised while entries are pending.

Parameters:
- SPRITE_NUM, 64, number of sprites / width of the hit vector; must be a power of 2.
- IDX_W, $clog2(SPRITE_NUM) = 6, width of a sprite index.
- FIFO_DEPTH, 16, number of queued hit indices; must be a power of 2.
- CNT_W, $clog2(FIFO_DEPTH)+1 = 5, width of the occupancy count.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- hitCheckBusy  in  1  busy flag from the collision checker.
- allSpriteHit  in  SPRITE_NUM  per-sprite hit vector; valid once hitCheckBusy has fallen.
- irqEn  in  1  interrupt enable.
- popReq  in  1  pop head entry; ignored when fifoEmpty.
- clrFlags  in  1  one-cycle pulse; clears overflow and frameDropped.
- hitIndex  out  IDX_W  head entry (first-word-fall-through); 0 when empty.
- fifoEmpty  out  1  FIFO holds no entries.
- fifoCount  out  CNT_W  occupancy, 0..FIFO_DEPTH.
- scanBusy  out  1  high while the scan FSM is in SCAN.
- scanDone  out  1  one-cycle pulse on the final scan cycle.
- overflow  out  1  sticky: at least one hit was dropped because the FIFO was full.
- frameDropped  out  1  sticky: a completion edge arrived while SCAN was active.
- hitIrq  out  1  irqEn & ~fifoEmpty, registered.
- hitFrameTag  out  4  present only with HIT_FRAME_TAG_EN (see below).

Behaviour:
- Reset (rstn low, asynchronous): FSM to IDLE; snapshot, scan counter, FIFO pointers and count cleared.
  - Outputs at reset: hitIndex=0, fifoEmpty=1, fifoCount=0, scanBusy=0, scanDone=0, overflow=0, frameDropped=0, hitIrq=0.
  - Reset mid-scan discards all pending and queued hits.
- busyDly: registered copy of hitCheckBusy (reset 0). Completion event = busyDly & ~hitCheckBusy.
- FSM IDLE:
  - On completion event: snapshot <= allSpriteHit, scanIdx <= 0, next state SCAN.
  - scanBusy rises the cycle after the event.
- FSM SCAN: one index per cycle.
  - If snapshot[scanIdx]=1, push scanIdx.
  - scanIdx increments; at scanIdx = SPRITE_NUM-1, scanDone=1 that cycle and return to IDLE.
  - Scan is exactly SPRITE_NUM cycles regardless of hit content.
  - Completion event while in SCAN: set frameDropped; snapshot unchanged; scan continues.
- Push rule:
  - Accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set.
  - Entries are stored in ascending index order within a frame.
- Pop rule:
  - popReq & ~fifoEmpty advances the read pointer.
  - hitIndex shows the new head the following cycle.
  - popReq while empty: no effect, no error.
- Simultaneous push and pop: count unchanged, both pointers advance. Push and pop on the same empty FIFO: the push is stored and the pop is ignored.
- fifoCount, fifoEmpty: registered, consistent with pointers every cycle. Pointers wrap modulo FIFO_DEPTH.
- clrFlags: clears overflow and frameDropped next cycle. If a set condition coincides with clrFlags, set wins.
- hitIrq: registered (irqEn & ~fifoEmpty_next), one-cycle latency from the push.

Optional Feature:
- Macro HIT_FRAME_TAG_EN.
- Defined:
  - A 4-bit frame counter (reset 0) increments on each accepted completion event (wraps 15->0).
  - Each FIFO entry stores {tag, index}; hitFrameTag shows the head entry's tag (0 when empty).
  - Frame-dropped events do not increment the counter.
- Undefined: no counter, no hitFrameTag port, FIFO entry width IDX_W.

Test Plan:
- Reset mid-scan: allSpriteHit=bit3|bit40, completion edge, assert rstn low at scan cycle 20 -> all outputs at reset values, fifoEmpty=1, no entries after release.
- Single frame: allSpriteHit = bits 5, 17, 63, irqEn=1; drop hitCheckBusy -> scanBusy for 64 cycles, scanDone on last; FIFO pops 5, 17, 63 in order; hitIrq high from the cycle after the first push until the pop that empties the FIFO.
- Overflow: allSpriteHit = 0xFFFF_FFFF_FFFF_FFFF, no pops -> fifoCount=16, entries 0..15, overflow=1; clrFlags -> overflow=0.
- Concurrent pop while full: same full vector, popReq held high throughout the scan -> all 64 indices observed on hitIndex in order 0..63, overflow stays 0.
- Frame collision: second busy falling edge 10 cycles into SCAN -> frameDropped=1, only first-frame indices queued; with HIT_FRAME_TAG_EN, first frame tag=1, next valid frame tag=2.
- Empty-pop and zero vector: allSpriteHit=0 -> scanDone pulse, fifoEmpty stays 1, hitIrq 0; popReq while empty -> fifoCount remains 0.
